// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a valid/ready request port, single-cycle logic/add/shift,
// multi-cycle shift-add multiply and restoring divide, and accumulator feedback as operand B.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             use_acc,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] acc,
    output logic             carry,
    output logic             zero,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH:0] WLIM = (WIDTH + 1)'(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_NAND = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_XNOR = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_DIV  = 4'd11;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;

    logic             p_valid;
    logic [3:0]       p_op;
    logic [WIDTH-1:0] p_a;
    logic [WIDTH-1:0] p_b;

    logic [WIDTH-1:0] x_a;
    logic [WIDTH-1:0] x_b;
    logic [WIDTH-1:0] x_p;
    logic [WIDTH:0]   rem;
    logic             dbz;

    logic             accept;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   s_sum;
    logic [WIDTH:0]   s_diff;
    logic             shift_big;
    logic [WIDTH-1:0] s_res;
    logic             s_carry;

    logic [WIDTH-1:0] mul_p_n;
    logic [WIDTH+1:0] rem_sh;
    logic [WIDTH+1:0] rem_sub;
    logic             ge;
    logic [WIDTH:0]   rem_n;
    logic [WIDTH-1:0] quo_n;

    assign in_ready  = (state == IDLE) && !rst;
    assign accept    = in_valid && in_ready;

    assign s_sum     = {1'b0, p_a} + {1'b0, p_b};
    assign s_diff    = {1'b0, p_a} - {1'b0, p_b};
    assign shift_big = {1'b0, p_b} >= WLIM;

    always_comb begin
        s_res   = '0;
        s_carry = 1'b0;
        unique case (p_op)
            OP_ADD: begin
                s_res   = s_sum[WIDTH-1:0];
                s_carry = s_sum[WIDTH];
            end
            OP_SUB: begin
                s_res   = s_diff[WIDTH-1:0];
                s_carry = ~s_diff[WIDTH];
            end
            OP_AND:  s_res = p_a & p_b;
            OP_NAND: s_res = ~(p_a & p_b);
            OP_OR:   s_res = p_a | p_b;
            OP_NOR:  s_res = ~(p_a | p_b);
            OP_XOR:  s_res = p_a ^ p_b;
            OP_XNOR: s_res = ~(p_a ^ p_b);
            OP_SHL:  s_res = shift_big ? '0 : (p_a << p_b);
            OP_SHR:  s_res = shift_big ? '0 : (p_a >> p_b);
            default: s_res = '0;
        endcase
    end

    // A single-cycle op retiring on this edge forwards its result as the new acc
    assign b_eff = use_acc ? (p_valid ? s_res : acc) : b;

    assign mul_p_n = x_p + (x_b[0] ? x_a : '0);

    // Borrow out of the widened subtract decides each quotient bit
    assign rem_sh  = {rem, x_a[WIDTH-1]};
    assign rem_sub = rem_sh - {2'b00, x_b};
    assign ge      = ~rem_sub[WIDTH+1];
    assign rem_n   = ge ? rem_sub[WIDTH:0] : rem_sh[WIDTH:0];
    assign quo_n   = {x_a[WIDTH-2:0], ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            p_valid     <= 1'b0;
            p_op        <= '0;
            p_a         <= '0;
            p_b         <= '0;
            x_a         <= '0;
            x_b         <= '0;
            x_p         <= '0;
            rem         <= '0;
            dbz         <= 1'b0;
            out_valid   <= 1'b0;
            result      <= '0;
            acc         <= '0;
            carry       <= 1'b0;
            zero        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            p_valid   <= 1'b0;
            if (p_valid) begin
                out_valid   <= 1'b1;
                result      <= s_res;
                acc         <= s_res;
                carry       <= s_carry;
                zero        <= (s_res == '0);
                div_by_zero <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt <= '0;
                        x_a <= a;
                        x_b <= b_eff;
                        x_p <= '0;
                        rem <= '0;
                        dbz <= (b_eff == '0);
                        if (op == OP_MUL) begin
                            state <= MUL;
                        end else if (op == OP_DIV) begin
                            state <= DIV;
                        end else begin
                            p_valid <= 1'b1;
                            p_op    <= op;
                            p_a     <= a;
                            p_b     <= b_eff;
                        end
                    end
                end
                MUL: begin
                    x_p <= mul_p_n;
                    x_a <= x_a << 1;
                    x_b <= x_b >> 1;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        out_valid   <= 1'b1;
                        result      <= mul_p_n;
                        acc         <= mul_p_n;
                        carry       <= 1'b0;
                        zero        <= (mul_p_n == '0);
                        div_by_zero <= 1'b0;
                    end
                end
                DIV: begin
                    rem <= rem_n;
                    x_a <= quo_n;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        out_valid   <= 1'b1;
                        result      <= quo_n;
                        acc         <= quo_n;
                        carry       <= 1'b0;
                        zero        <= (quo_n == '0);
                        div_by_zero <= dbz;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: WIDTH=16 and WIDTH=8 instances checked
// against an arithmetic reference model with randomized and directed ops.
module tb_alu_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv16, rdy16, ua16, ov16, c16, z16, dz16;
    logic [3:0]  op16;
    logic [15:0] a16, b16, res16, acc16;

    logic       iv8, rdy8, ua8, ov8, c8, z8, dz8;
    logic [3:0] op8;
    logic [7:0] a8, b8, res8, acc8;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] macc16 = '0;
    logic [7:0]  macc8 = '0;

    alu_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(rdy16),
        .op(op16), .a(a16), .b(b16), .use_acc(ua16),
        .out_valid(ov16), .result(res16), .acc(acc16),
        .carry(c16), .zero(z16), .div_by_zero(dz16)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy8),
        .op(op8), .a(a8), .b(b8), .use_acc(ua8),
        .out_valid(ov8), .result(res8), .acc(acc8),
        .carry(c8), .zero(z8), .div_by_zero(dz8)
    );

    function automatic void model(input int w, input int o, input longint x,
                                  input longint y, output longint r,
                                  output bit c, output bit dz);
        longint m;
        m = (longint'(1) << w) - 1;
        r = 0;
        c = 1'b0;
        dz = 1'b0;
        case (o)
            0: begin r = (x + y) & m; c = ((x + y) >> w) != 0; end
            1: begin r = (x - y) & m; c = (x >= y); end
            2: r = x & y;
            3: r = ~(x & y) & m;
            4: r = x | y;
            5: r = ~(x | y) & m;
            6: r = x ^ y;
            7: r = ~(x ^ y) & m;
            8: r = (y >= w) ? 0 : ((x << y) & m);
            9: r = (y >= w) ? 0 : (x >> y);
            10: r = (x * y) & m;
            11: begin
                if (y == 0) begin r = m; dz = 1'b1; end
                else r = x / y;
            end
            default: r = 0;
        endcase
    endfunction

    task automatic run16(input logic [3:0] o, input logic [15:0] xa,
                         input logic [15:0] xb, input logic ua,
                         output int lat, output int rlow);
        lat = 0;
        rlow = 0;
        op16 = o; a16 = xa; b16 = xb; ua16 = ua; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        if (!rdy16) rlow++;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (ov16) begin lat = n; break; end
            if (!rdy16) rlow++;
        end
    endtask

    task automatic run8(input logic [3:0] o, input logic [7:0] xa,
                        input logic [7:0] xb, input logic ua,
                        output int lat, output int rlow);
        lat = 0;
        rlow = 0;
        op8 = o; a8 = xa; b8 = xb; ua8 = ua; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        if (!rdy8) rlow++;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (ov8) begin lat = n; break; end
            if (!rdy8) rlow++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({rdy16, ov16, res16, acc16, c16, z16, dz16} !== '0) begin
            n_bad++;
            $display("FAIL reset16: rdy=%b ov=%b res=%h acc=%h c=%b z=%b dz=%b, want all 0",
                     rdy16, ov16, res16, acc16, c16, z16, dz16);
        end
        n_cmp++;
        if ({rdy8, ov8, res8, acc8, c8, z8, dz8} !== '0) begin
            n_bad++;
            $display("FAIL reset8: rdy=%b ov=%b res=%h acc=%h, want all 0",
                     rdy8, ov8, res8, acc8);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({rdy16, rdy8} !== 2'b11) begin
            n_bad++;
            $display("FAIL reset_release: rdy16=%b rdy8=%b, want 1 1", rdy16, rdy8);
        end
    endtask

    task automatic test_add_wrap;
        int lat, rl;
        run16(4'd0, 16'hFFFF, 16'h0001, 1'b0, lat, rl);
        n_cmp++;
        if ({res16, c16, z16, dz16, acc16} !== {16'h0000, 3'b110, 16'h0000}) begin
            n_bad++;
            $display("FAIL add_wrap: res=%h c=%b z=%b dz=%b acc=%h, want 0000 1 1 0 0000",
                     res16, c16, z16, dz16, acc16);
        end
        n_cmp++;
        if (lat !== 1 || rl !== 0) begin
            n_bad++;
            $display("FAIL add_latency: lat=%0d rdy_low=%0d, want 1 0", lat, rl);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (ov16 !== 1'b0) begin
            n_bad++;
            $display("FAIL add_pulse: out_valid=%b on second cycle, want 0", ov16);
        end
        macc16 = 16'h0000;
    endtask

    task automatic test_chain;
        int lat, rl;
        op16 = 4'd8; a16 = 16'd11; b16 = 16'd5; ua16 = 1'b0; iv16 = 1'b1;
        @(posedge clk); #1;
        op16 = 4'd1; a16 = 16'd400; b16 = 16'hDEAD; ua16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0; ua16 = 1'b0;
        n_cmp++;
        if ({ov16, res16, acc16, c16, z16} !== {1'b1, 16'h0160, 16'h0160, 2'b00}) begin
            n_bad++;
            $display("FAIL chain_shl: ov=%b res=%h acc=%h c=%b z=%b, want 1 0160 0160 0 0",
                     ov16, res16, acc16, c16, z16);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({ov16, res16, acc16, c16, z16} !== {1'b1, 16'd48, 16'd48, 2'b10}) begin
            n_bad++;
            $display("FAIL chain_sub: ov=%b res=%0d acc=%0d c=%b z=%b, want 1 48 48 1 0",
                     ov16, res16, acc16, c16, z16);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (ov16 !== 1'b0) begin
            n_bad++;
            $display("FAIL chain_idle: out_valid=%b, want 0", ov16);
        end
        run16(4'd9, 16'h8001, 16'd16, 1'b0, lat, rl);
        n_cmp++;
        if ({res16, c16, z16, lat} !== {16'h0000, 2'b01, 32'd1}) begin
            n_bad++;
            $display("FAIL shr_wide: res=%h c=%b z=%b lat=%0d, want 0000 0 1 1",
                     res16, c16, z16, lat);
        end
        macc16 = 16'h0000;
    endtask

    task automatic test_mul_ignore;
        int lat, nov, rl;
        logic [15:0] got;
        lat = 0; nov = 0; got = '0;
        op16 = 4'd10; a16 = 16'd300; b16 = 16'd300; ua16 = 1'b0; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        rl = rdy16 ? 0 : 1;
        for (int n = 1; n <= 20; n++) begin
            if (n >= 3 && n <= 6) begin
                iv16 = 1'b1; op16 = 4'd0; a16 = 16'd1; b16 = 16'd1;
            end else begin
                iv16 = 1'b0;
            end
            @(posedge clk); #1;
            if (ov16) begin
                nov++;
                if (lat == 0) begin lat = n; got = res16; end
            end else if (lat == 0 && !rdy16) begin
                rl++;
            end
        end
        n_cmp++;
        if (lat !== 16 || nov !== 1 || rl !== 16) begin
            n_bad++;
            $display("FAIL mul_timing: lat=%0d pulses=%0d rdy_low=%0d, want 16 1 16",
                     lat, nov, rl);
        end
        n_cmp++;
        if ({got, res16, acc16, c16, z16, dz16} !== {16'h5F90, 16'h5F90, 16'h5F90, 3'b000}) begin
            n_bad++;
            $display("FAIL mul_result: got=%h res=%h acc=%h c=%b z=%b dz=%b, want 5F90 hold",
                     got, res16, acc16, c16, z16, dz16);
        end
        macc16 = 16'h5F90;
    endtask

    task automatic test_div;
        int lat, rl;
        run16(4'd11, 16'd1000, 16'd7, 1'b0, lat, rl);
        n_cmp++;
        if ({res16, dz16, c16, z16, acc16, lat, rl} !==
            {16'd142, 3'b000, 16'd142, 32'd16, 32'd16}) begin
            n_bad++;
            $display("FAIL div_1000_7: res=%0d dz=%b acc=%0d lat=%0d rdy_low=%0d, want 142 0 142 16 16",
                     res16, dz16, acc16, lat, rl);
        end
        run16(4'd11, 16'd5, 16'd0, 1'b0, lat, rl);
        n_cmp++;
        if ({res16, dz16, c16, z16, acc16, lat} !==
            {16'hFFFF, 3'b100, 16'hFFFF, 32'd16}) begin
            n_bad++;
            $display("FAIL div_by_zero: res=%h dz=%b acc=%h lat=%0d, want FFFF 1 FFFF 16",
                     res16, dz16, acc16, lat);
        end
        macc16 = 16'hFFFF;
    endtask

    task automatic test_random_multi;
        int lat, rl, el;
        longint r;
        bit c, dz;
        logic [3:0] o;
        logic [15:0] x, y, e;
        logic u;
        longint bb;
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 3))
                0: o = 4'd10;
                1: o = 4'd11;
                default: o = 4'($urandom_range(0, 15));
            endcase
            x = 16'($urandom);
            y = 16'($urandom);
            if (o == 4'd11 && $urandom_range(0, 3) == 0) y = 16'd0;
            if (o == 4'd8 || o == 4'd9) y = 16'($urandom_range(0, 20));
            u = 1'($urandom_range(0, 1));
            bb = u ? longint'(macc16) : longint'(y);
            model(16, int'(o), longint'(x), bb, r, c, dz);
            e = r[15:0];
            el = (o == 4'd10 || o == 4'd11) ? 16 : 1;
            run16(o, x, y, u, lat, rl);
            n_cmp++;
            if ({res16, c16, z16, dz16, acc16} !== {e, c, (e == 16'h0), dz, e}) begin
                n_bad++;
                $display("FAIL rand16 op=%0d a=%h B=%h: res=%h c=%b z=%b dz=%b acc=%h, want %h %b %b %b",
                         o, x, bb[15:0], res16, c16, z16, dz16, acc16, e, c, (e == 16'h0), dz);
            end
            n_cmp++;
            if (lat !== el || rl !== ((el == 16) ? 16 : 0)) begin
                n_bad++;
                $display("FAIL rand16_timing op=%0d: lat=%0d rdy_low=%0d, want %0d",
                         o, lat, rl, el);
            end
            macc16 = e;
        end
    endtask

    task automatic test_back_to_back;
        logic [18:0] q[$];
        logic [18:0] e;
        longint r, bb;
        bit c, dz;
        logic [3:0] o;
        logic [15:0] x, y;
        logic u;
        int got;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            o = 4'($urandom_range(0, 15));
            if (o == 4'd10) o = 4'd12;
            else if (o == 4'd11) o = 4'd13;
            x = 16'($urandom);
            y = (o == 4'd8 || o == 4'd9) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            u = 1'($urandom_range(0, 1));
            bb = u ? longint'(macc16) : longint'(y);
            model(16, int'(o), longint'(x), bb, r, c, dz);
            q.push_back({r[15:0], c, (r == 0), dz});
            macc16 = r[15:0];
            op16 = o; a16 = x; b16 = y; ua16 = u; iv16 = 1'b1;
            @(posedge clk); #1;
            if (ov16 && q.size() > 0) begin
                e = q.pop_front();
                got++;
                n_cmp++;
                if ({res16, c16, z16, dz16, acc16} !== {e, e[18:3]}) begin
                    n_bad++;
                    $display("FAIL b2b #%0d: res=%h c=%b z=%b dz=%b acc=%h, want %h %b %b %b",
                             got, res16, c16, z16, dz16, acc16, e[18:3], e[2], e[1], e[0]);
                end
            end else if (ov16) begin
                got++;
            end
        end
        iv16 = 1'b0; ua16 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (ov16 && q.size() > 0) begin
                e = q.pop_front();
                got++;
                n_cmp++;
                if ({res16, c16, z16, dz16, acc16} !== {e, e[18:3]}) begin
                    n_bad++;
                    $display("FAIL b2b_tail: res=%h c=%b z=%b dz=%b acc=%h, want %h %b %b %b",
                             res16, c16, z16, dz16, acc16, e[18:3], e[2], e[1], e[0]);
                end
            end else if (ov16) begin
                got++;
            end
        end
        n_cmp++;
        if (q.size() != 0 || got != 40) begin
            n_bad++;
            $display("FAIL b2b_count: results=%0d left=%0d, want 40 0", got, q.size());
        end
    endtask

    task automatic test_reset_mid;
        int lat, rl, nov;
        run16(4'd0, 16'd2, 16'd3, 1'b0, lat, rl);
        n_cmp++;
        if ({res16, acc16} !== {16'd5, 16'd5}) begin
            n_bad++;
            $display("FAIL pre_reset_add: res=%0d acc=%0d, want 5 5", res16, acc16);
        end
        op16 = 4'd10; a16 = 16'h1234; b16 = 16'h0F0F; ua16 = 1'b0; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if ({ov16, res16, acc16, c16, z16, dz16, rdy16} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid: ov=%b res=%h acc=%h c=%b z=%b dz=%b rdy=%b, want all 0",
                     ov16, res16, acc16, c16, z16, dz16, rdy16);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (rdy16 !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_ready: rdy=%b, want 1", rdy16);
        end
        nov = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (ov16) nov++;
        end
        n_cmp++;
        if (nov !== 0 || acc16 !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_mid_abort: pulses=%0d acc=%h, want 0 0000", nov, acc16);
        end
        run16(4'd0, 16'd2, 16'd3, 1'b0, lat, rl);
        n_cmp++;
        if ({res16, acc16, lat} !== {16'd5, 16'd5, 32'd1}) begin
            n_bad++;
            $display("FAIL post_reset_add: res=%0d acc=%0d lat=%0d, want 5 5 1",
                     res16, acc16, lat);
        end
        macc16 = 16'd5;
    endtask

    task automatic test_width8;
        int lat, rl, el;
        longint r, bb;
        bit c, dz;
        logic [3:0] o;
        logic [7:0] x, y, e;
        logic u;
        run8(4'd10, 8'd15, 8'd17, 1'b0, lat, rl);
        n_cmp++;
        if ({res8, acc8, c8, z8, dz8, lat, rl} !== {8'd255, 8'd255, 3'b000, 32'd8, 32'd8}) begin
            n_bad++;
            $display("FAIL w8_mul: res=%0d acc=%0d lat=%0d rdy_low=%0d, want 255 255 8 8",
                     res8, acc8, lat, rl);
        end
        run8(4'd11, 8'd200, 8'd3, 1'b0, lat, rl);
        n_cmp++;
        if ({res8, dz8, lat} !== {8'd66, 1'b0, 32'd8}) begin
            n_bad++;
            $display("FAIL w8_div: res=%0d dz=%b lat=%0d, want 66 0 8", res8, dz8, lat);
        end
        run8(4'd0, 8'hF0, 8'h20, 1'b0, lat, rl);
        n_cmp++;
        if ({res8, c8, z8, lat} !== {8'h10, 2'b10, 32'd1}) begin
            n_bad++;
            $display("FAIL w8_add: res=%h c=%b z=%b lat=%0d, want 10 1 0 1", res8, c8, z8, lat);
        end
        macc8 = 8'h10;
        for (int i = 0; i < 12; i++) begin
            o = 4'($urandom_range(0, 15));
            x = 8'($urandom);
            y = 8'($urandom);
            if (o == 4'd8 || o == 4'd9) y = 8'($urandom_range(0, 12));
            if (o == 4'd11 && $urandom_range(0, 2) == 0) y = 8'd0;
            u = 1'($urandom_range(0, 1));
            bb = u ? longint'(macc8) : longint'(y);
            model(8, int'(o), longint'(x), bb, r, c, dz);
            e = r[7:0];
            el = (o == 4'd10 || o == 4'd11) ? 8 : 1;
            run8(o, x, y, u, lat, rl);
            n_cmp++;
            if ({res8, c8, z8, dz8, acc8, lat} !== {e, c, (e == 8'h0), dz, e, el}) begin
                n_bad++;
                $display("FAIL rand8 op=%0d a=%h B=%h: res=%h c=%b z=%b dz=%b lat=%0d, want %h %b %b %b %0d",
                         o, x, bb[7:0], res8, c8, z8, dz8, lat, e, c, (e == 8'h0), dz, el);
            end
            macc8 = e;
        end
    endtask

    initial begin
        iv16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; ua16 = 1'b0;
        iv8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; ua8 = 1'b0;
        test_reset;
        test_add_wrap;
        test_chain;
        test_mul_ignore;
        test_div;
        test_random_multi;
        test_back_to_back;
        test_reset_mid;
        test_width8;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, sequential successor to the team's 16-bit combinational ALU datapath. It accepts one operation at a time over a valid/ready handshake and completes logic, add/sub and shift operations in one cycle. Multiply (shift-add) and divide (restoring) run as multi-cycle operations of WIDTH iterations. An internal accumulator can feed back as operand B, which replaces the separate input-register/mux stage.

## Interface
Parameters:
- WIDTH, 16, operand/result width (≥4).

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept; `(state==IDLE) && !rst`.
- op  in  4  opcode, see Operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- use_acc  in  1  1: operand B = accumulator, `b` ignored.
- out_valid  out  1  one-cycle pulse; result/flags updated this cycle.
- result  out  WIDTH  registered result.
- acc  out  WIDTH  accumulator; loads `result` on every out_valid.
- carry  out  1  ADD carry-out / SUB no-borrow (a≥B); 0 for other ops.
- zero  out  1  result==0.
- div_by_zero  out  1  DIV with B==0; 0 for other ops.

## Operation
- Accept occurs on a rising edge with `in_valid && in_ready`; `a`, `B` and `op` are latched at that edge.
- Opcodes:
  - 0 ADD: a+B mod 2^WIDTH.
  - 1 SUB: a−B mod 2^WIDTH.
  - 2 AND, 3 NAND, 4 OR, 5 NOR, 6 XOR, 7 XNOR: bitwise.
  - 8 SHL: a<<B.
  - 9 SHR: a>>B, logical. For both shifts, B≥WIDTH gives 0.
  - 10 MUL: low WIDTH bits of a×B, unsigned.
  - 11 DIV: unsigned quotient a/B.
  - 12 CLR: result 0; the accumulator clears via the normal load.
  - 13–15: result 0, out_valid still pulses.
- FSM states: IDLE, MUL, DIV.
  - IDLE→MUL or IDLE→DIV on accepting op 10/11.
  - All other ops stay in IDLE.
  - MUL/DIV run WIDTH iterations on a counter 0..WIDTH−1, then return to IDLE.
- MUL: per iteration, if multiplier LSB is 1, add the multiplicand to the WIDTH-bit partial product. Then shift the multiplicand left and the multiplier right.
- DIV: restoring, MSB first. Remainder is WIDTH+1 bits and is internal only.
  - If B==0: result all ones, div_by_zero=1, full WIDTH-cycle latency kept.
- Flags and result hold their values between out_valid pulses.
- in_valid is ignored while in_ready=0; there is no queuing.

## Timing
- Reset: state IDLE, counter 0, and all of result, acc, carry, zero, div_by_zero, out_valid = 0. in_ready=0 while rst is high, 1 on the first cycle after release.
- Reset mid-MUL/DIV aborts the operation: no out_valid, acc keeps its reset value 0.
- Single-cycle ops:
  - Accept at edge k → out_valid=1 and result valid after edge k+1.
  - in_ready stays 1, so back-to-back accepts give one result per cycle.
- MUL/DIV:
  - Accept at edge k → in_ready=0 after edges k..k+WIDTH−1.
  - Result and out_valid appear after edge k+WIDTH; latency is WIDTH cycles.
  - in_ready=1 in the same cycle as out_valid, so a new accept on edge k+WIDTH+1 is legal.
- use_acc samples the acc value present at the accept edge. This includes an acc value just loaded on that edge's preceding out_valid, i.e. a back-to-back dependent op sees the new acc.
- out_valid is never asserted in two consecutive cycles for the same operation.

## Test plan
- Reset then ADD: a=16'hFFFF, B=16'h0001 → after 1 cycle result=0, carry=1, zero=1, acc=0, out_valid for exactly 1 cycle.
- SHL then chained SUB: SHL a=11, b=5 → result=352 (16'h0160). Next cycle SUB with use_acc=1, a=400 → result=48, carry=1. SHR with b=16 → result 0.
- MUL a=300, b=300 → in_ready low 16 cycles, result=16'h5F90 (90000 mod 65536) 16 cycles after accept. in_valid pulsed mid-operation is ignored.
- DIV a=1000, b=7 → result=142 after 16 cycles, div_by_zero=0. DIV a=5, b=0 → result=16'hFFFF, div_by_zero=1, same latency.
- Reset asserted asynchronously (between edges) 5 cycles into a MUL → outputs zero immediately, no out_valid, in_ready=1 after release. A following ADD 2+3 returns 5.
- WIDTH=8 instance: MUL 15×17=255, DIV 200/3=66, each with 8-cycle latency. ADD 8'hF0+8'h20 → 8'h10, carry=1.
